// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants for the pipelined CLA adder: lookahead group width and
// the pipeline-depth derivation from operand width.
package cla_pipe_adder_pkg;

   localparam int GROUP_W = 4;

   function automatic int num_groups(input int width);
      return width / GROUP_W;
   endfunction

   function automatic bit width_ok(input int width);
      return (width >= GROUP_W) && (width % GROUP_W == 0);
   endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// 4-bit carry-lookahead group: sum, group propagate/generate and carry-out.
module cla_group4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       Pg,
   output logic       Gg,
   output logic       co
);

   logic [3:0] p, g, c;

   assign p = a ^ b;
   assign g = a & b;

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c;
   assign Pg = &p;
   assign Gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign co = Gg | (Pg & ci);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one 4-bit lookahead group resolved per
// stage, whole pipe advances together under a single valid/ready enable.
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             P,
   output logic             G
);

   localparam int L = num_groups(WIDTH);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a positive multiple of 4");
   end

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   logic [L-1:0]            vld, c_q, p_q, g_q, cm_q;
   logic [L-1:0][WIDTH-1:0] s_q, a_q, b_q;

   logic [L-1:0][3:0] ga, gb, gs;
   logic [L-1:0]      gci, gp, gg, gco;

   assign en       = out_ready | ~out_valid;
   assign in_ready = en;
   assign b_eff    = sub ? ~b : b;
   assign c0       = sub | cin;

   // Stage 0 works on the live inputs; later stages on the previous stage's registers.
   for (genvar k = 0; k < L; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign ga[k]  = a[GROUP_W-1:0];
         assign gb[k]  = b_eff[GROUP_W-1:0];
         assign gci[k] = c0;
      end else begin : g_rest
         assign ga[k]  = a_q[k-1][GROUP_W*k +: GROUP_W];
         assign gb[k]  = b_q[k-1][GROUP_W*k +: GROUP_W];
         assign gci[k] = c_q[k-1];
      end

      cla_group4 u_grp (
         .a  (ga[k]),
         .b  (gb[k]),
         .ci (gci[k]),
         .s  (gs[k]),
         .Pg (gp[k]),
         .Gg (gg[k]),
         .co (gco[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld  <= '0;
         c_q  <= '0;
         p_q  <= '0;
         g_q  <= '0;
         cm_q <= '0;
         s_q  <= '0;
         a_q  <= '0;
         b_q  <= '0;
      end else if (en) begin
         vld[0]  <= in_valid;
         a_q[0]  <= a;
         b_q[0]  <= b_eff;
         s_q[0]  <= WIDTH'(gs[0]);
         c_q[0]  <= gco[0];
         p_q[0]  <= gp[0];
         g_q[0]  <= gg[0];
         cm_q[0] <= ga[0][3] ^ gb[0][3] ^ gs[0][3];
         for (int k = 1; k < L; k++) begin
            vld[k]  <= vld[k-1];
            a_q[k]  <= a_q[k-1];
            b_q[k]  <= b_q[k-1];
            // Upper sum bits are still zero here, so OR drops the new group in place.
            s_q[k]  <= s_q[k-1] | (WIDTH'(gs[k]) << (GROUP_W * k));
            c_q[k]  <= gco[k];
            p_q[k]  <= gp[k] & p_q[k-1];
            g_q[k]  <= gg[k] | (gp[k] & g_q[k-1]);
            cm_q[k] <= ga[k][3] ^ gb[k][3] ^ gs[k][3];
         end
      end
   end

   // Final-stage operands and early MSB-carry taps have no consumer.
   logic unused_bits;
   assign unused_bits = ^{a_q[L-1], b_q[L-1], cm_q};

   assign out_valid = vld[L-1];
   assign sum       = s_q[L-1];
   assign cout      = c_q[L-1];
   assign ovf       = cm_q[L-1] ^ c_q[L-1];
   assign P         = p_q[L-1];
   assign G         = g_q[L-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and streaming checks for cla_pipe_adder at WIDTH=16 (4 stages).
module tb_cla_pipe_adder;

   localparam int WIDTH = 16;
   localparam int L     = 4;

   logic             clk = 1'b0;
   logic             rst, in_valid, in_ready, cin, sub;
   logic             out_valid, out_ready, cout, ovf, P, G;
   logic [WIDTH-1:0] a, b, sum;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .P         (P),
      .G         (G)
   );

   // Reference: {cout, ovf, sum} from plain wide arithmetic and the sign rule.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
      logic [15:0] ye;
      logic [16:0] r;
      ye = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, ye} + {16'd0, (s | ci)};
      return {r[16], (x[15] == ye[15]) && (r[15] != x[15]), r[15:0]};
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, sum, cout, ovf, P, G, in_ready} !== {1'b0, 16'h0, 4'b0000, 1'b1}) begin
         n_fail++;
         $display("FAIL reset: got v=%b sum=%h c=%b o=%b P=%b G=%b rdy=%b, want v=0 sum=0000 c=0 o=0 P=0 G=0 rdy=1",
                  out_valid, sum, cout, ovf, P, G, in_ready);
      end
      rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [15:0] va [7] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h0010};
      logic [15:0] vb [7] = '{16'h0001, 16'h0000, 16'h0001, 16'h0007, 16'h0001, 16'h0FFF, 16'h0010};
      logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      // {sum, cout, ovf, P, G}
      logic [19:0] ve [7] = '{{16'h0000, 4'b1001}, {16'hFFFF, 4'b0010}, {16'h8000, 4'b0100},
                              {16'hFFFE, 4'b0000}, {16'h7FFF, 4'b1101}, {16'h2234, 4'b0000},
                              {16'h0000, 4'b1010}};
      for (int i = 0; i < 7; i++) begin
         a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; sub = ~sub;
         repeat (2) @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early[%0d]: out_valid=%b want 0", i, out_valid);
         end
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid, sum, cout, ovf, P, G} !== {1'b1, ve[i]}) begin
            n_fail++;
            $display("FAIL directed[%0d]: got v=%b sum=%h c=%b o=%b P=%b G=%b, want v=1 sum=%h c/o/P/G=%b",
                     i, out_valid, sum, cout, ovf, P, G, ve[i][19:4], ve[i][3:0]);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL directed_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   // Streams n random ops; out_ready drops for sl cycles starting at iteration st.
   task automatic run_stream(input int n, input int st, input int sl, input string tag);
      logic [15:0] oa [16], ob [16];
      logic        oc [16], os [16];
      logic [17:0] sb [$];
      logic [15:0] held;
      logic        stall, exp_v;
      int          src, got;
      src = 0; got = 0; held = '0;
      for (int i = 0; i < n; i++) begin
         oa[i] = 16'($urandom); ob[i] = 16'($urandom);
         oc[i] = 1'($urandom); os[i] = 1'($urandom);
      end
      for (int it = 0; it < n + sl + 12; it++) begin
         if (out_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL %s_extra[%0d]: unexpected result sum=%h", tag, it, sum);
            end else if ({cout, ovf, sum} !== sb[0]) begin
               n_fail++;
               $display("FAIL %s_data[%0d]: got c=%b o=%b sum=%h, want c=%b o=%b sum=%h",
                        tag, it, cout, ovf, sum, sb[0][17], sb[0][16], sb[0][15:0]);
            end
         end
         if (sl == 0) begin
            exp_v = (it >= L) && (it < L + n);
            n_checks++;
            if (out_valid !== exp_v) begin
               n_fail++;
               $display("FAIL %s_valid[%0d]: out_valid=%b want %b", tag, it, out_valid, exp_v);
            end
         end
         stall = (it >= st) && (it < st + sl);
         if (stall && it > st) begin
            n_checks++;
            if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, held}) begin
               n_fail++;
               $display("FAIL %s_hold[%0d]: got v=%b rdy=%b sum=%h, want v=1 rdy=0 sum=%h",
                        tag, it, out_valid, in_ready, sum, held);
            end
         end
         if (it == st) held = sum;
         out_ready = !stall;
         if (src < n) begin
            a = oa[src]; b = ob[src]; cin = oc[src]; sub = os[src]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready && sb.size() != 0) begin
            void'(sb.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            src++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (got != n || sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_count: consumed %0d pending %0d, want %0d and 0", tag, got, sb.size(), n);
      end
   endtask

   task automatic test_back_to_back();
      run_stream(10, 1000, 0, "b2b");
   endtask

   task automatic test_stall();
      run_stream(8, 5, 3, "stall");
   endtask

   task automatic test_reset_mid();
      int bad;
      for (int i = 0; i < 3; i++) begin
         a = 16'h0100 * 16'(i + 1); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_flush: out_valid=%b want 0", out_valid);
      end
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rst_mid_ghost: %0d stale results seen, want 0", bad);
      end
      a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_early: out_valid=%b want 0", out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h3334, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_mid_new: got v=%b sum=%h c=%b o=%b, want v=1 sum=3334 c=0 o=0",
                  out_valid, sum, cout, ovf);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
